// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle CPU controller: ISA opcodes, datapath
// select encodings, FSM state enum and the packed control vector.
package multicycle_ctrl_pkg;

  localparam int OPW = 4;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOP  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQZ = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_LI   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_PASSB = 3'd5;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_A    = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_JMP = 2'b10;

  // Encoding 4'hF is deliberately unused and recovers to S_IF1.
  typedef enum logic [3:0] {
    S_IF1   = 4'd0,
    S_IF2   = 4'd1,
    S_ID    = 4'd2,
    S_EXR   = 4'd3,
    S_EXI   = 4'd4,
    S_WB    = 4'd5,
    S_MA    = 4'd6,
    S_MR    = 4'd7,
    S_MR2   = 4'd8,
    S_WBL   = 4'd9,
    S_MW    = 4'd10,
    S_BR    = 4'd11,
    S_JP    = 4'd12,
    S_HALTE = 4'd13,
    S_HALT  = 4'd14
  } state_e;

  typedef struct packed {
    logic       IRload;
    logic       Aload;
    logic       Bload;
    logic       ALUOutLoad;
    logic       MDRload;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       MemToReg;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic       PCWrite;
    logic [1:0] PCSel;
    logic       AddrSel;
    logic       halted;
    logic       illegal_op;
    logic       retire;
  } ctrl_t;

  function automatic logic is_rtype(input logic [3:0] op);
    return (op <= OP_XOR);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hB) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: decoded instruction status in, control
// strobes and status flags out. The controller uses the master side.
interface multicycle_ctrl_if;
  logic [3:0] opcode;
  logic       zero;
  logic       IRload;
  logic       Aload;
  logic       Bload;
  logic       ALUOutLoad;
  logic       MDRload;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       MemToReg;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic       PCWrite;
  logic [1:0] PCSel;
  logic       AddrSel;
  logic       halted;
  logic       illegal_op;
  logic       retire;

  modport master (
    input  opcode, zero,
    output IRload, Aload, Bload, ALUOutLoad, MDRload, RegWrite,
           MemRead, MemWrite, MemToReg, ALUSrcA, ALUSrcB, ALUOp,
           PCWrite, PCSel, AddrSel, halted, illegal_op, retire
  );

  modport slave (
    output opcode, zero,
    input  IRload, Aload, Bload, ALUOutLoad, MDRload, RegWrite,
           MemRead, MemWrite, MemToReg, ALUSrcA, ALUSrcB, ALUOp,
           PCWrite, PCSel, AddrSel, halted, illegal_op, retire
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Moore output decode: maps the current state (plus opcode in ID/EXR and the
// zero flag in BR) to the full datapath control vector. Purely combinational.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [3:0] opcode_i,
  input  logic       zero_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_IF2: begin
        ctrl_o.MemRead = 1'b1;
        ctrl_o.AddrSel = 1'b0;
        ctrl_o.IRload  = 1'b1;
        ctrl_o.PCWrite = 1'b1;
        ctrl_o.PCSel   = PCSEL_SEQ;
      end
      S_ID: begin
        ctrl_o.Aload = 1'b1;
        ctrl_o.Bload = 1'b1;
        // Branch target uses the already-incremented PC, so PC+1+imm.
        if (opcode_i == OP_BEQZ) begin
          ctrl_o.ALUSrcA    = SRCA_PC;
          ctrl_o.ALUSrcB    = SRCB_IMM;
          ctrl_o.ALUOp      = ALU_ADD;
          ctrl_o.ALUOutLoad = 1'b1;
        end
        if (opcode_i == OP_NOP) begin
          ctrl_o.retire = 1'b1;
        end
        if (is_illegal(opcode_i)) begin
          ctrl_o.retire     = 1'b1;
          ctrl_o.illegal_op = 1'b1;
        end
      end
      S_EXR: begin
        ctrl_o.ALUSrcA    = SRCA_A;
        ctrl_o.ALUSrcB    = SRCB_B;
        ctrl_o.ALUOp      = opcode_i[2:0];
        ctrl_o.ALUOutLoad = 1'b1;
      end
      S_EXI: begin
        ctrl_o.ALUSrcB    = SRCB_IMM;
        ctrl_o.ALUOp      = ALU_PASSB;
        ctrl_o.ALUOutLoad = 1'b1;
      end
      S_WB: begin
        ctrl_o.RegWrite = 1'b1;
        ctrl_o.MemToReg = 1'b0;
        ctrl_o.retire   = 1'b1;
      end
      S_MA: begin
        ctrl_o.ALUSrcA    = SRCA_ZERO;
        ctrl_o.ALUSrcB    = SRCB_IMM;
        ctrl_o.ALUOp      = ALU_ADD;
        ctrl_o.ALUOutLoad = 1'b1;
      end
      S_MR: begin
        ctrl_o.MemRead = 1'b1;
        ctrl_o.AddrSel = 1'b1;
      end
      S_MR2: begin
        ctrl_o.MemRead = 1'b1;
        ctrl_o.AddrSel = 1'b1;
        ctrl_o.MDRload = 1'b1;
      end
      S_WBL: begin
        ctrl_o.RegWrite = 1'b1;
        ctrl_o.MemToReg = 1'b1;
        ctrl_o.retire   = 1'b1;
      end
      S_MW: begin
        ctrl_o.MemWrite = 1'b1;
        ctrl_o.AddrSel  = 1'b1;
        ctrl_o.retire   = 1'b1;
      end
      S_BR: begin
        ctrl_o.PCWrite = zero_i;
        ctrl_o.PCSel   = PCSEL_BR;
        ctrl_o.retire  = 1'b1;
      end
      S_JP: begin
        ctrl_o.PCWrite = 1'b1;
        ctrl_o.PCSel   = PCSEL_JMP;
        ctrl_o.retire  = 1'b1;
      end
      S_HALTE: begin
        ctrl_o.halted = 1'b1;
        ctrl_o.retire = 1'b1;
      end
      S_HALT: begin
        ctrl_o.halted = 1'b1;
      end
      // S_IF1 and any undefined encoding behave as instruction fetch.
      default: begin
        ctrl_o.MemRead    = 1'b1;
        ctrl_o.AddrSel    = 1'b0;
        ctrl_o.ALUSrcA    = SRCA_PC;
        ctrl_o.ALUSrcB    = SRCB_ONE;
        ctrl_o.ALUOp      = ALU_ADD;
        ctrl_o.ALUOutLoad = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit von Neumann CPU: state register,
// next-state sequencing, and reset-gated Moore outputs via the decode block.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   bus
);

  state_e         state_q, state_d;
  logic [OPW-1:0] opcode;
  ctrl_t          ctrl_dec;
  ctrl_t          ctrl;

  assign opcode = bus.opcode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IF1;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF1;
    case (state_q)
      S_IF1: state_d = S_IF2;
      S_IF2: state_d = S_ID;
      S_ID: begin
        if (is_rtype(opcode))                       state_d = S_EXR;
        else if (opcode == OP_LI)                   state_d = S_EXI;
        else if (opcode == OP_LD || opcode == OP_ST) state_d = S_MA;
        else if (opcode == OP_BEQZ)                 state_d = S_BR;
        else if (opcode == OP_JMP)                  state_d = S_JP;
        else if (opcode == OP_HALT)                 state_d = S_HALTE;
        else                                        state_d = S_IF1;
      end
      S_EXR:   state_d = S_WB;
      S_EXI:   state_d = S_WB;
      S_MA:    state_d = (opcode == OP_LD) ? S_MR : S_MW;
      S_MR:    state_d = S_MR2;
      S_MR2:   state_d = S_WBL;
      S_HALTE: state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF1;
    endcase
  end

  multicycle_ctrl_decode u_decode (
    .state_i  (state_q),
    .opcode_i (bus.opcode),
    .zero_i   (bus.zero),
    .ctrl_o   (ctrl_dec)
  );

  // Reset gates outputs combinationally so an in-flight write dies instantly.
  assign ctrl = reset ? '0 : ctrl_dec;

  assign bus.IRload     = ctrl.IRload;
  assign bus.Aload      = ctrl.Aload;
  assign bus.Bload      = ctrl.Bload;
  assign bus.ALUOutLoad = ctrl.ALUOutLoad;
  assign bus.MDRload    = ctrl.MDRload;
  assign bus.RegWrite   = ctrl.RegWrite;
  assign bus.MemRead    = ctrl.MemRead;
  assign bus.MemWrite   = ctrl.MemWrite;
  assign bus.MemToReg   = ctrl.MemToReg;
  assign bus.ALUSrcA    = ctrl.ALUSrcA;
  assign bus.ALUSrcB    = ctrl.ALUSrcB;
  assign bus.ALUOp      = ctrl.ALUOp;
  assign bus.PCWrite    = ctrl.PCWrite;
  assign bus.PCSel      = ctrl.PCSel;
  assign bus.AddrSel    = ctrl.AddrSel;
  assign bus.halted     = ctrl.halted;
  assign bus.illegal_op = ctrl.illegal_op;
  assign bus.retire     = ctrl.retire;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a behavioural datapath+memory obeys the control
// strobes, and an ISA-level interpreter predicts architectural results.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();
  multicycle_ctrl u_dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Datapath driven by the controller
  logic [15:0] mem [0:65535];
  logic [15:0] rdata;
  logic [15:0] pc, ir, a, b, aluout, mdr;
  logic [15:0] r [0:7];
  logic [15:0] addr, srca, srcb, alu_y;
  logic [2:0]  p1;
  logic [22:0] all_out;

  assign bus.opcode = ir[15:12];
  assign bus.zero   = (r[ir[11:9]] == 16'd0);
  assign p1 = (ir[15:12] == 4'h7) ? ir[11:9] : ir[8:6];
  assign all_out = {bus.IRload, bus.Aload, bus.Bload, bus.ALUOutLoad, bus.MDRload,
                    bus.RegWrite, bus.MemRead, bus.MemWrite, bus.MemToReg, bus.ALUSrcA,
                    bus.ALUSrcB, bus.ALUOp, bus.PCWrite, bus.PCSel, bus.AddrSel,
                    bus.halted, bus.illegal_op, bus.retire};

  always_comb begin
    addr = bus.AddrSel ? aluout : pc;
    case (bus.ALUSrcA)
      2'b01:   srca = a;
      2'b10:   srca = 16'd0;
      default: srca = pc;
    endcase
    case (bus.ALUSrcB)
      2'b00:   srcb = b;
      2'b01:   srcb = 16'd1;
      2'b10:   srcb = {{8{ir[7]}}, ir[7:0]};
      default: srcb = 16'd0;
    endcase
    case (bus.ALUOp)
      3'd0:    alu_y = srca + srcb;
      3'd1:    alu_y = srca - srcb;
      3'd2:    alu_y = srca & srcb;
      3'd3:    alu_y = srca | srcb;
      3'd4:    alu_y = srca ^ srcb;
      3'd5:    alu_y = srcb;
      default: alu_y = 16'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0; ir <= '0; a <= '0; b <= '0; aluout <= '0; mdr <= '0;
      for (int i = 0; i < 8; i++) r[i] <= '0;
    end else begin
      if (bus.IRload)     ir <= rdata;
      if (bus.Aload)      a <= r[p1];
      if (bus.Bload)      b <= r[ir[5:3]];
      if (bus.ALUOutLoad) aluout <= alu_y;
      if (bus.MDRload)    mdr <= rdata;
      if (bus.RegWrite)   r[ir[11:9]] <= bus.MemToReg ? mdr : aluout;
      if (bus.PCWrite)    pc <= (bus.PCSel == 2'b10) ? {4'b0, ir[11:0]} : aluout;
    end
  end

  always @(posedge clk) begin
    if (bus.MemRead)  rdata <= mem[addr];
    if (bus.MemWrite) mem[addr] = a;
  end

  // ISA-level reference
  logic [15:0] m_pc;
  logic [15:0] m_r [0:7];
  logic [15:0] m_mem [0:65535];

  task automatic isa_step(output int cyc, output int e_ill, output bit hlt, output int e_mdr,
                          output int e_mw, output int e_rw, output int e_pcw,
                          output bit st, output logic [15:0] st_addr);
    logic [15:0] w, simm, x, y;
    logic [3:0]  op;
    logic [2:0]  rd;
    w = m_mem[m_pc]; op = w[15:12]; rd = w[11:9];
    x = m_r[w[8:6]]; y = m_r[w[5:3]];
    simm = {{8{w[7]}}, w[7:0]};
    e_ill = 0; hlt = 0; e_mdr = 0; e_mw = 0; e_rw = 0; e_pcw = 1; st = 0; st_addr = simm;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
        cyc = 5; e_rw = 1;
        m_r[rd] = (op == 0) ? x + y : (op == 1) ? x - y : (op == 2) ? (x & y) :
                  (op == 3) ? (x | y) : (x ^ y);
        m_pc = m_pc + 1;
      end
      4'h5: begin cyc = 3; m_pc = m_pc + 1; end
      4'h6: begin cyc = 7; e_rw = 1; e_mdr = 1; m_r[rd] = m_mem[simm]; m_pc = m_pc + 1; end
      4'h7: begin cyc = 5; e_mw = 1; st = 1; m_mem[simm] = m_r[rd]; m_pc = m_pc + 1; end
      4'h8: begin
        cyc = 4;
        if (m_r[rd] == 0) begin e_pcw = 2; m_pc = m_pc + 1 + simm; end
        else m_pc = m_pc + 1;
      end
      4'h9: begin cyc = 4; e_pcw = 2; m_pc = {4'b0, w[11:0]}; end
      4'hA: begin cyc = 5; e_rw = 1; m_r[rd] = simm; m_pc = m_pc + 1; end
      4'hF: begin cyc = 4; hlt = 1; m_pc = m_pc + 1; end
      default: begin cyc = 3; e_ill = 1; m_pc = m_pc + 1; end
    endcase
  endtask

  task automatic poke(input logic [15:0] ad, input logic [15:0] w);
    mem[ad] = w; m_mem[ad] = w;
  endtask

  // Holds reset, loads random memory, releases at a negedge; leaves time at negedge+1.
  task automatic start_run(input bit skip_release);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_outputs", all_out, 23'd0);
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      mem[i] = w; m_mem[i] = w;
    end
    m_pc = 16'd0;
    for (int i = 0; i < 8; i++) m_r[i] = 16'd0;
    if (!skip_release) release_reset();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_pc", pc, 16'd0);
    chk("post_reset_memread", bus.MemRead, 1'b1);
    chk("post_reset_alusrcb", bus.ALUSrcB, 2'b01);
  endtask

  task automatic run_prog(input int max_instr);
    int cyc, e_cyc, e_ill, e_mdr, e_mw, e_rw, e_pcw;
    int n_ill, n_mdr, n_mw, n_rw, n_pcw, clash, bad;
    bit hlt, st, done, tmo;
    logic [15:0] st_addr;
    for (int n = 0; n < max_instr; n++) begin
      isa_step(e_cyc, e_ill, hlt, e_mdr, e_mw, e_rw, e_pcw, st, st_addr);
      cyc = 0; n_ill = 0; n_mdr = 0; n_mw = 0; n_rw = 0; n_pcw = 0; clash = 0;
      done = 0; tmo = 0;
      while (!done) begin
        cyc++;
        n_ill += int'(bus.illegal_op);
        n_mdr += int'(bus.MDRload);
        n_mw  += int'(bus.MemWrite);
        n_rw  += int'(bus.RegWrite);
        n_pcw += int'(bus.PCWrite);
        clash += int'(bus.MemRead & bus.MemWrite);
        if (bus.retire) done = 1;
        else if (cyc >= 12) begin done = 1; tmo = 1; end
        else begin @(negedge clk); #1; end
      end
      chk("retire_timeout", tmo, 1'b0);
      if (tmo) return;
      chk("instr_cycles", cyc, e_cyc);
      chk("illegal_pulses", n_ill, e_ill);
      chk("mdrload_pulses", n_mdr, e_mdr);
      chk("memwrite_pulses", n_mw, e_mw);
      chk("regwrite_pulses", n_rw, e_rw);
      chk("pcwrite_pulses", n_pcw, e_pcw);
      chk("rd_wr_overlap", clash, 0);
      chk("halted_flag", bus.halted, hlt);
      if (hlt) begin
        bad = 0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk); #1;
          if (!bus.halted || bus.retire || bus.MemRead || bus.PCWrite ||
              bus.MemWrite || bus.RegWrite || bus.IRload) bad++;
        end
        chk("halt_hold", bad, 0);
        return;
      end
      @(posedge clk); #1;
      chk("arch_pc", pc, m_pc);
      for (int i = 0; i < 8; i++) chk($sformatf("arch_r%0d", i), r[i], m_r[i]);
      if (st) chk("arch_mem", mem[st_addr], m_mem[st_addr]);
      @(negedge clk); #1;
    end
  endtask

  initial begin
    // Reset asserted while the FSM sits in EXR
    start_run(1'b0);
    poke(16'h0000, 16'h0650);
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("exr_aluoutload", bus.ALUOutLoad, 1'b1);
    chk("exr_alusrca", bus.ALUSrcA, 2'b01);
    reset = 1'b1;
    #1;
    chk("mid_reset_outputs", all_out, 23'd0);
    release_reset();
    chk("restart_aluoutload", bus.ALUOutLoad, 1'b1);
    run_prog(6);

    // Directed program: LI/LI/ADD/ST/LD, JMP, BEQZ taken, illegal, JMP, BEQZ not taken, HALT
    start_run(1'b1);
    poke(16'h0000, 16'hA205);
    poke(16'h0001, 16'hA403);
    poke(16'h0002, 16'h0650);
    poke(16'h0003, 16'h7620);
    poke(16'h0004, 16'h6820);
    poke(16'h0005, 16'h9010);
    poke(16'h0010, 16'h80FD);
    poke(16'h000E, 16'hC000);
    poke(16'h000F, 16'h9ABC);
    poke(16'h0ABC, 16'h8205);
    poke(16'h0ABD, 16'hF000);
    release_reset();
    run_prog(20);
    chk("prog_r3", r[3], 16'h0008);
    chk("prog_r4", r[4], 16'h0008);
    chk("prog_mem20", mem[16'h0020], 16'h0008);
    chk("prog_halted", bus.halted, 1'b1);

    // Random memory images executed from PC 0
    for (int t = 0; t < 10; t++) begin
      start_run(1'b0);
      run_prog(60);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
